dl_or_rr_sched: RTL and testbench

//   Round-robin scheduler that shares one registered bitwise-OR unit among
//   NUM_REQ requesters. Each requester offers an operand pair (in0, in1) on a

---
 rtl/dl_or_rr_sched.sv | 96 +++++++++
 tb/tb_dl_or_rr_sched.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dl_or_rr_sched.sv
// Round-robin scheduler sharing one registered OR unit among NUM_REQ clients.
// Ports: req_valid/req_ready/req_in0/req_in1 per client; rsp_* result channel.
module dl_or_rr_sched #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_BITS = 32,
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*NUM_BITS-1:0]  req_in0,
  input  logic [NUM_REQ*NUM_BITS-1:0]  req_in1,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [NUM_BITS-1:0]          rsp_data,
  output logic [ID_W-1:0]              rsp_id
);

  logic                accept;
  logic                found;
  logic                xfer;
  logic [ID_W-1:0]     win;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                valid_q, valid_d;
  logic [NUM_BITS-1:0] data_q, data_d;
  logic [NUM_BITS-1:0] op0, op1;

  // Output slot is free, or its result leaves this cycle.
  assign accept = !valid_q || rsp_ready;

  // Scan ptr, ptr+1, ... with wrap; first valid requester wins.
  always_comb begin : arb
    int              idx;
    logic [ID_W-1:0] cand;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = ID_W'(idx);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign xfer = found && accept;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[win] = 1'b1;
  end

  assign op0 = req_in0[int'(win)*NUM_BITS +: NUM_BITS];
  assign op1 = req_in1[int'(win)*NUM_BITS +: NUM_BITS];

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      valid_d = 1'b1;
      data_d  = op0 | op1;
      id_d    = win;
      if (win == ID_W'(NUM_REQ - 1)) ptr_d = '0;
      else                           ptr_d = win + 1'b1;
    end else if (rsp_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  assign rsp_valid = valid_q;
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_dl_or_rr_sched.sv
// Directed bench for dl_or_rr_sched (4x32 instance plus a 1x1 instance).
// Checks reset, single op, wrap, backpressure, fairness and corner data.
module tb_dl_or_rr_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_in0, req_in1;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [31:0]  rsp_data;
  logic [1:0]   rsp_id;

  logic         v1, r1, in0_1, in1_1, rv1, rr1, d1;
  logic [0:0]   id1;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_data [4];
  int          exp_id;

  always #5 clk = ~clk;

  dl_or_rr_sched #(.NUM_REQ(4), .NUM_BITS(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_in0   (req_in0),
    .req_in1   (req_in1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  dl_or_rr_sched #(.NUM_REQ(1), .NUM_BITS(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (v1),
    .req_ready (r1),
    .req_in0   (in0_1),
    .req_in1   (in1_1),
    .rsp_valid (rv1),
    .rsp_ready (rr1),
    .rsp_data  (d1),
    .rsp_id    (id1)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i,
                         input logic [31:0] a,
                         input logic [31:0] b);
    req_in0[i*32 +: 32] = a;
    req_in1[i*32 +: 32] = b;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_in0 = '0;
    req_in1 = '0;
    rsp_ready = 1'b1;
    v1 = 1'b0; in0_1 = 1'b0; in1_1 = 1'b0; rr1 = 1'b1;
    edge1();
    edge1();
    chk("rst_valid", 64'(rsp_valid), 64'(0));
    chk("rst_data", 64'(rsp_data), 64'(0));
    chk("rst_id", 64'(rsp_id), 64'(0));
    chk("rst_ready", 64'(req_ready), 64'(0));
    rst_n = 1'b1;

    // single op from requester 1
    set_ops(1, 32'h0F0F_0000, 32'h0000_00F0);
    req_valid = 4'b0010;
    #1;
    chk("single_ready", 64'(req_ready), 64'(4'b0010));
    edge1();
    req_valid = 4'b0000;
    chk("single_valid", 64'(rsp_valid), 64'(1));
    chk("single_data", 64'(rsp_data), 64'(32'h0F0F_00F0));
    chk("single_id", 64'(rsp_id), 64'(1));
    edge1();
    chk("drain_valid", 64'(rsp_valid), 64'(0));
    chk("drain_hold", 64'(rsp_data), 64'(32'h0F0F_00F0));

    // ptr=2: grant 3 with all-ones data, ptr wraps to 0
    set_ops(3, 32'hFFFF_FFFF, 32'h0);
    req_valid = 4'b1000;
    #1;
    chk("w3_ready", 64'(req_ready), 64'(4'b1000));
    edge1();
    chk("w3_id", 64'(rsp_id), 64'(3));
    chk("w3_data", 64'(rsp_data), 64'(32'hFFFF_FFFF));

    // ptr=0: req 0 and 2 valid -> 0 then 2
    set_ops(0, 32'h0, 32'h0);
    set_ops(2, 32'h1234_0000, 32'h0000_5678);
    req_valid = 4'b0101;
    #1;
    chk("w0_ready", 64'(req_ready), 64'(4'b0001));
    edge1();
    chk("w0_id", 64'(rsp_id), 64'(0));
    chk("w0_data", 64'(rsp_data), 64'(0));
    chk("w2_ready", 64'(req_ready), 64'(4'b0100));
    edge1();
    chk("w2_id", 64'(rsp_id), 64'(2));
    chk("w2_data", 64'(rsp_data), 64'(32'h1234_5678));

    // ptr=3: only req 1 valid -> grant 1
    req_valid = 4'b0010;
    #1;
    chk("w1_ready", 64'(req_ready), 64'(4'b0010));
    edge1();
    chk("w1_id", 64'(rsp_id), 64'(1));
    chk("w1_data", 64'(rsp_data), 64'(32'h0F0F_00F0));

    // backpressure with everyone requesting, ptr=2
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_ready", 64'(req_ready), 64'(0));
      edge1();
      chk("bp_valid", 64'(rsp_valid), 64'(1));
      chk("bp_data", 64'(rsp_data), 64'(32'h0F0F_00F0));
      chk("bp_id", 64'(rsp_id), 64'(1));
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release", 64'(req_ready), 64'(4'b0100));
    edge1();
    chk("bp_rel_id", 64'(rsp_id), 64'(2));
    chk("bp_rel_valid", 64'(rsp_valid), 64'(1));

    // fairness: ptr=3, expect 3,0,1,2,... every cycle
    exp_data[0] = 32'h0;
    exp_data[1] = 32'h0F0F_00F0;
    exp_data[2] = 32'h1234_5678;
    exp_data[3] = 32'hFFFF_FFFF;
    exp_id = 3;
    for (int c = 0; c < 8; c++) begin
      edge1();
      chk("fair_valid", 64'(rsp_valid), 64'(1));
      chk("fair_id", 64'(rsp_id), 64'(exp_id));
      chk("fair_data", 64'(rsp_data), 64'(exp_data[exp_id]));
      exp_id = (exp_id + 1) % 4;
    end

    // asynchronous reset while a result is held
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
    edge1();
    chk("pre_rst_valid", 64'(rsp_valid), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(rsp_valid), 64'(0));
    chk("arst_data", 64'(rsp_data), 64'(0));
    chk("arst_id", 64'(rsp_id), 64'(0));
    edge1();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    #1;
    chk("post_rst_ready", 64'(req_ready), 64'(4'b0100));
    edge1();
    req_valid = 4'b0000;
    chk("post_rst_id", 64'(rsp_id), 64'(2));
    chk("post_rst_data", 64'(rsp_data), 64'(32'h1234_5678));

    // single-requester, single-bit instance
    v1 = 1'b1; in0_1 = 1'b1; in1_1 = 1'b0;
    #1;
    chk("n1_ready", 64'(r1), 64'(1));
    edge1();
    chk("n1_valid", 64'(rv1), 64'(1));
    chk("n1_data", 64'(d1), 64'(1));
    chk("n1_id", 64'(id1), 64'(0));
    in0_1 = 1'b0; in1_1 = 1'b0;
    edge1();
    chk("n1_zero", 64'(d1), 64'(0));
    chk("n1_id2", 64'(id1), 64'(0));
    in1_1 = 1'b1;
    edge1();
    chk("n1_in1", 64'(d1), 64'(1));
    chk("n1_valid2", 64'(rv1), 64'(1));
    v1 = 1'b0;
    edge1();
    chk("n1_drain", 64'(rv1), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
